// File: rtl/openhw_intdiv_iter.sv
// openhw_intdiv_iter
//   Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and the RV64
//   W forms. It produces one quotient bit per cycle. Divide-by-zero and signed
//   overflow skip the iteration and finish after one cycle.
// Ports
//   clk, reset      clock; asynchronous active-low reset
//   IntDivE         divide/remainder op present in Execute (start request)
//   Funct3E         100 DIV, 101 DIVU, 110 REM, 111 REMU
//   W64E            32-bit op (RV64 only); the result is sign-extended from bit 31
//   ForwardedSrcAE  dividend
//   ForwardedSrcBE  divisor
//   StallE          result not yet consumed; hold in DONE
//   FlushE          abort the current operation / suppress a start
//   DivBusyE        stall request, from the start cycle until DONE
//   DivDoneE        DivResultE valid
//   DivResultE      quotient or remainder, zero when not DONE
module openhw_intdiv_iter #(
  parameter int XLEN = 64,
  parameter bit RV64 = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            IntDivE,
  input  logic [2:0]      Funct3E,
  input  logic            W64E,
  input  logic [XLEN-1:0] ForwardedSrcAE,
  input  logic [XLEN-1:0] ForwardedSrcBE,
  input  logic            StallE,
  input  logic            FlushE,
  output logic            DivBusyE,
  output logic            DivDoneE,
  output logic [XLEN-1:0] DivResultE
);

  localparam int CW    = $clog2(XLEN);
  localparam bit HAS_W = RV64 && (XLEN > 32);
  // For W ops the dividend is pre-shifted into the top half of quo, so
  // 32 shifts drain it into rem.
  localparam int WSH   = (XLEN > 32) ? 32 : 0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            w_q, w_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic            remsel_q, remsel_d;

  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic s);
    logic [XLEN-1:0] r;
    r = v;
    for (int i = 32; i < XLEN; i++) r[i] = s & v[31];
    return r;
  endfunction

  logic            start, is_w, sgn, a_neg, b_neg, div0, ovf, ge;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, int_min, w_min, res_raw, res;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] trial;
  logic            unused_bits;

  assign unused_bits = ^{Funct3E[2], rem_q[XLEN]};

  always_comb begin
    start   = IntDivE & ~FlushE;
    is_w    = HAS_W & W64E;
    sgn     = ~Funct3E[0];
    a_ext   = is_w ? ext32(ForwardedSrcAE, sgn) : ForwardedSrcAE;
    b_ext   = is_w ? ext32(ForwardedSrcBE, sgn) : ForwardedSrcBE;
    a_neg   = sgn & a_ext[XLEN-1];
    b_neg   = sgn & b_ext[XLEN-1];
    a_abs   = a_neg ? -a_ext : a_ext;
    b_abs   = b_neg ? -b_ext : b_ext;
    int_min = {1'b1, {(XLEN-1){1'b0}}};
    w_min   = {XLEN{1'b1}} << 31;
    div0    = (b_ext == '0);
    ovf     = sgn & (b_ext == {XLEN{1'b1}}) & (a_ext == (is_w ? w_min : int_min));

    // One restoring step; rem stays below div, so rem_sh fits in XLEN+1 bits
    // and the top bit of trial is the borrow.
    rem_sh  = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    trial   = {1'b0, rem_sh} - {2'b00, div_q};
    ge      = ~trial[XLEN+1];

    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    w_d      = w_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    remsel_d = remsel_q;

    case (state_q)
      IDLE: if (start) begin
        w_d      = is_w;
        remsel_d = Funct3E[1];
        div_d    = b_abs;
        if (div0) begin
          quo_d   = '1;
          rem_d   = {1'b0, a_ext};
          negq_d  = 1'b0;
          negr_d  = 1'b0;
          state_d = DONE;
        end else if (ovf) begin
          quo_d   = a_ext;
          rem_d   = '0;
          negq_d  = 1'b0;
          negr_d  = 1'b0;
          state_d = DONE;
        end else begin
          quo_d   = is_w ? (a_abs << WSH) : a_abs;
          rem_d   = '0;
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          cnt_d   = is_w ? CW'(31) : CW'(XLEN-1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        rem_d = ge ? trial[XLEN:0] : rem_sh;
        quo_d = {quo_q[XLEN-2:0], ge};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: if (!StallE) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (FlushE && state_q != IDLE) state_d = IDLE;

    res_raw = remsel_q ? (negr_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0])
                       : (negq_q ? -quo_q : quo_q);
    res     = w_q ? ext32(res_raw, 1'b1) : res_raw;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      w_q      <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      remsel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      w_q      <= w_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      remsel_q <= remsel_d;
    end
  end

  // Outputs decode the state flop directly. Reset clears them immediately,
  // and a partial result never reaches DivResultE.
  assign DivDoneE   = (state_q == DONE);
  assign DivBusyE   = (state_q == BUSY) | ((state_q == IDLE) & start);
  assign DivResultE = (state_q == DONE) ? res : '0;

endmodule

// File: tb/tb_openhw_intdiv_iter.sv
// Directed bench for openhw_intdiv_iter (XLEN=64, RV64=1).
module tb_openhw_intdiv_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        IntDivE = 1'b0;
  logic [2:0]  Funct3E = 3'b000;
  logic        W64E = 1'b0;
  logic [63:0] A = '0, B = '0;
  logic        StallE = 1'b0;
  logic        FlushE = 1'b0;
  logic        DivBusyE, DivDoneE;
  logic [63:0] DivResultE;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  openhw_intdiv_iter #(.XLEN(64), .RV64(1)) dut (
    .clk(clk), .reset(reset), .IntDivE(IntDivE), .Funct3E(Funct3E), .W64E(W64E),
    .ForwardedSrcAE(A), .ForwardedSrcBE(B), .StallE(StallE), .FlushE(FlushE),
    .DivBusyE(DivBusyE), .DivDoneE(DivDoneE), .DivResultE(DivResultE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op for a single cycle, scramble the operand ports afterwards,
  // then measure the start-to-done latency and check the result.
  task automatic run(input string tag, input logic [2:0] f3, input logic w,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp, input int lat);
    int cyc;
    @(negedge clk);
    IntDivE = 1'b1; Funct3E = f3; W64E = w; A = a; B = b;
    #1 chk({tag, " busy@start"}, 64'(DivBusyE), 64'd1);
    @(posedge clk); #1;
    IntDivE = 1'b0;
    A = {$urandom, $urandom}; B = {$urandom, $urandom};
    W64E = 1'($urandom); Funct3E = 3'($urandom);
    cyc = 1;
    while (DivDoneE !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(lat));
    chk({tag, " result"}, DivResultE, exp);
    chk({tag, " busy@done"}, 64'(DivBusyE), 64'd0);
    @(posedge clk); #1;
    chk({tag, " done drop"}, 64'(DivDoneE), 64'd0);
  endtask

  initial begin
    int seen;
    #1 reset = 1'b0;
    #1;
    chk("reset busy", 64'(DivBusyE), 64'd0);
    chk("reset done", 64'(DivDoneE), 64'd0);
    chk("reset result", DivResultE, 64'd0);
    @(negedge clk); reset = 1'b1;

    run("div 20/-3",     F_DIV,  1'b0, 64'd20, -64'sd3, 64'hFFFF_FFFF_FFFF_FFFA, 65);
    run("rem 20%-3",     F_REM,  1'b0, 64'd20, -64'sd3, 64'd2, 65);
    run("rem -20%3",     F_REM,  1'b0, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run("remu max%10",   F_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'd5, 65);
    run("divu x/0",      F_DIVU, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run("rem 7%0",       F_REM,  1'b0, 64'd7, 64'd0, 64'd7, 1);
    run("div ovf",       F_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
    run("rem ovf",       F_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run("divw ovf",      F_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run("divuw",         F_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run("divw hi junk",  F_DIV,  1'b1, 64'hDEAD_0000_0000_0064, 64'h1234_0000_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 33);
    run("remw -20%3",    F_REM,  1'b1, 64'h5555_5555_FFFF_FFEC, 64'hAAAA_AAAA_0000_0003, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run("remuw",         F_REMU, 1'b1, 64'h0000_0000_FFFF_FFF0, 64'd7, 64'd2, 33);

    // Flush at the 10th BUSY cycle
    @(negedge clk);
    IntDivE = 1'b1; Funct3E = F_DIV; W64E = 1'b0; A = 64'd100; B = 64'd7;
    @(posedge clk); #1 IntDivE = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); FlushE = 1'b1;
    @(posedge clk); #1 FlushE = 1'b0;
    chk("flush busy", 64'(DivBusyE), 64'd0);
    chk("flush done", 64'(DivDoneE), 64'd0);
    seen = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (DivDoneE !== 1'b0) seen = 1;
    end
    chk("flush no done pulse", 64'(seen), 64'd0);
    run("div after flush", F_DIV, 1'b0, 64'd100, 64'd7, 64'd14, 65);

    // Flush coincident with start: nothing starts
    @(negedge clk);
    IntDivE = 1'b1; FlushE = 1'b1; Funct3E = F_DIV; A = 64'd100; B = 64'd7;
    #1 chk("flush@start busy", 64'(DivBusyE), 64'd0);
    @(posedge clk); #1 IntDivE = 1'b0; FlushE = 1'b0;
    chk("flush@start busy after", 64'(DivBusyE), 64'd0);
    repeat (3) @(posedge clk);
    #1 chk("flush@start no done", 64'(DivDoneE), 64'd0);

    // Result held while stalled
    @(negedge clk);
    StallE = 1'b1; IntDivE = 1'b1; Funct3E = F_DIVU; W64E = 1'b0; A = 64'd100; B = 64'd7;
    @(posedge clk); #1 IntDivE = 1'b0;
    repeat (64) @(posedge clk);
    #1 chk("stall done", 64'(DivDoneE), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("stall hold done", 64'(DivDoneE), 64'd1);
    chk("stall hold result", DivResultE, 64'd14);
    @(negedge clk); StallE = 1'b0;
    @(posedge clk); #1 chk("stall release", 64'(DivDoneE), 64'd0);

    // Reset asserted mid-BUSY
    @(negedge clk);
    IntDivE = 1'b1; Funct3E = F_DIV; A = 64'd20; B = -64'sd3;
    @(posedge clk); #1 IntDivE = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("midreset busy", 64'(DivBusyE), 64'd0);
    chk("midreset done", 64'(DivDoneE), 64'd0);
    chk("midreset result", DivResultE, 64'd0);
    @(negedge clk); reset = 1'b1;
    repeat (70) @(posedge clk);
    #1 chk("midreset no done", 64'(DivDoneE), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
